// File: rtl/uart_txq_if.sv
// Bundles the enqueue side and the UART transmitter side of uart_txq.
// slave is the queue itself; master is whatever drives it.
interface uart_txq_if;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_ovf;
  logic [7:0] tx_din;
  logic       tx_send;
  logic       tx_busy;

  modport slave (
    input  wr_data, wr_en, clr_ovf, tx_busy,
    output full, empty, overflow, tx_din, tx_send
  );

  modport master (
    output wr_data, wr_en, clr_ovf, tx_busy,
    input  full, empty, overflow, tx_din, tx_send
  );
endinterface

// File: rtl/uart_txq.sv
// Byte FIFO feeding a UART transmitter through a send/busy handshake.
// Optional drop counter enabled by defining UART_TXQ_DROPCNT_EN.
module uart_txq #(
  parameter int AWidth = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_txq_if.slave       bus,
`ifdef UART_TXQ_DROPCNT_EN
  output logic [7:0]      drop_count,
`endif
  output logic [1:0]      dbg_state,
  output logic [AWidth:0] dbg_count
);

  localparam int Depth = 1 << AWidth;
  localparam logic [AWidth:0] DepthC = (AWidth + 1)'(Depth);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                load;
  logic [7:0]          mem [Depth];
  logic [AWidth-1:0]   wr_ptr, rd_ptr;
  logic [AWidth:0]     count;
  logic [7:0]          tx_din_q;
  logic                overflow_q;
  logic                full_w, empty_w;
  logic                wr_acc, wr_drop, pop;

  assign full_w  = (count == DepthC);
  assign empty_w = (count == '0);
  assign wr_acc  = bus.wr_en && !full_w;
  assign wr_drop = bus.wr_en && full_w;
  // Handshake: tx_send rises with tx_din valid and holds until the transmitter
  // answers with tx_busy=1; that sampled edge is the one and only pop.
  assign pop     = (state == REQ) && bus.tx_busy;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AWidth'(1);
      if (pop)    rd_ptr <= rd_ptr + AWidth'(1);
      if (wr_acc && !pop)      count <= count + (AWidth + 1)'(1);
      else if (!wr_acc && pop) count <= count - (AWidth + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else if (bus.clr_ovf) overflow_q <= 1'b0;
    else if (wr_drop)     overflow_q <= 1'b1;
  end

`ifdef UART_TXQ_DROPCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_count <= 8'h00;
    else if (bus.clr_ovf) drop_count <= 8'h00;
    else if (wr_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_din_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (load) tx_din_q <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (!empty_w && !bus.tx_busy) begin
        state_nxt = REQ;
        load      = 1'b1;
      end
      REQ:  if (bus.tx_busy)  state_nxt = WAIT;
      WAIT: if (!bus.tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.overflow = overflow_q;
  assign bus.tx_din   = tx_din_q;
  assign bus.tx_send  = (state == REQ);
  assign dbg_state    = state;
  assign dbg_count    = count;

endmodule

// File: tb/tb_uart_txq.sv
// Randomized bench for uart_txq: queue reference model plus a UART responder
// that acknowledges, holds, or mutes the transmitter handshake.
module tb_uart_txq;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  uart_txq_if bus();
  logic [1:0]  dbg_state;
  logic [AW:0] dbg_count;
`ifdef UART_TXQ_DROPCNT_EN
  logic [7:0]  drop_count;
`endif

  uart_txq #(.AWidth(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
`ifdef UART_TXQ_DROPCNT_EN
    .drop_count(drop_count),
`endif
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bytes accepted but not yet handed to the UART
  logic [7:0] exp_q[$];
  int   model_cnt, model_drops, n_sent, total_acc;
  bit   model_ovf, pop_next, prev_send;
  logic [7:0] last_din, last_cap;
  // UART responder: umode 0 acknowledges, 1 holds busy, 2 never answers
  int   umode, ustate, wcnt, ack_dly, bcnt, fixed_dly;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    exp_q.delete();
    model_cnt = 0; model_ovf = 0; model_drops = 0;
    pop_next = 0; prev_send = 0; last_din = 8'h00;
    ustate = 0;
  endtask

  task automatic check_state();
    checks++;
    if (dbg_count !== 5'(model_cnt)) begin
      failures++; $display("FAIL count: got %0d expected %0d", dbg_count, model_cnt);
    end
    checks++;
    if (bus.full !== (model_cnt == DEPTH)) begin
      failures++; $display("FAIL full: got %b expected %b", bus.full, model_cnt == DEPTH);
    end
    checks++;
    if (bus.empty !== (model_cnt == 0)) begin
      failures++; $display("FAIL empty: got %b expected %b", bus.empty, model_cnt == 0);
    end
    checks++;
    if (bus.overflow !== model_ovf) begin
      failures++; $display("FAIL overflow: got %b expected %b", bus.overflow, model_ovf);
    end
`ifdef UART_TXQ_DROPCNT_EN
    checks++;
    if (drop_count !== 8'(model_drops)) begin
      failures++; $display("FAIL drop_count: got %0d expected %0d", drop_count, model_drops);
    end
`endif
    checks++;
    if (bus.tx_send === 1'b1 && !prev_send) begin
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL send_empty: got tx_send=1 with din %0h expected no send", bus.tx_din);
      end else if (bus.tx_din !== exp_q[0]) begin
        failures++; $display("FAIL send_data: got %0h expected %0h", bus.tx_din, exp_q[0]);
      end
      last_din = bus.tx_din;
    end else if (bus.tx_din !== last_din) begin
      failures++; $display("FAIL din_stable: got %0h expected %0h", bus.tx_din, last_din);
    end
    prev_send = (bus.tx_send === 1'b1);
  endtask

  task automatic uart_step();
    logic [7:0] front;
    pop_next = 0;
    if (umode == 1) begin
      bus.tx_busy = 1'b1;
      checks++;
      if (bus.tx_send !== 1'b0) begin
        failures++; $display("FAIL send_while_busy: got %b expected 0", bus.tx_send);
      end
    end else if (umode == 2) begin
      bus.tx_busy = 1'b0;
    end else begin
      case (ustate)
        0: begin
          bus.tx_busy = 1'b0;
          if (bus.tx_send === 1'b1) begin
            ustate = 1; wcnt = 0;
            ack_dly = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 3);
          end
        end
        1: begin
          checks++;
          if (bus.tx_send !== 1'b1) begin
            failures++; $display("FAIL send_hold: got %b expected 1", bus.tx_send);
          end
          wcnt++;
          if (wcnt >= ack_dly) begin
            bus.tx_busy = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL capture: got %0h expected nothing queued", bus.tx_din);
            end else begin
              front = exp_q.pop_front();
              if (bus.tx_din !== front) begin
                failures++; $display("FAIL capture: got %0h expected %0h", bus.tx_din, front);
              end
            end
            last_cap = bus.tx_din;
            n_sent++;
            pop_next = 1;
            bcnt = $urandom_range(1, 3);
            ustate = 2;
          end
        end
        default: begin
          checks++;
          if (bus.tx_send !== 1'b0) begin
            failures++; $display("FAIL send_after_ack: got %b expected 0", bus.tx_send);
          end
          bcnt--;
          if (bcnt == 0) begin
            bus.tx_busy = 1'b0;
            ustate = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: check outputs, advance the UART model, then drive the enqueue side
  task automatic cycle(input bit we, input logic [7:0] d, input bit clr, input bit only_on_pop);
    bit w, acc, drop;
    @(negedge clk);
    check_state();
    uart_step();
    w    = we && (!only_on_pop || pop_next);
    acc  = w && (model_cnt < DEPTH);
    drop = w && !acc;
    model_cnt = model_cnt + int'(acc) - int'(pop_next);
    if (acc) begin
      exp_q.push_back(d);
      total_acc++;
    end
    if (clr) begin
      model_ovf = 0; model_drops = 0;
    end else if (drop) begin
      model_ovf = 1;
      if (model_drops < 255) model_drops++;
    end
    bus.wr_en = w; bus.wr_data = d; bus.clr_ovf = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((model_cnt != 0 || ustate != 0 || bus.tx_send !== 1'b0) && guard < 3000) begin
      idle(1);
      guard++;
    end
    checks++;
    if (guard >= 3000) begin
      failures++; $display("FAIL drain_timeout: got %0d queued expected 0", model_cnt);
    end
    idle(2);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.clr_ovf = 1'b0; bus.tx_busy = 1'b0;
    #1;
    checks++;
    if (bus.tx_send !== 1'b0) begin failures++; $display("FAIL rst_send: got %b expected 0", bus.tx_send); end
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b expected 1", bus.empty); end
    checks++;
    if (bus.full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b expected 0", bus.full); end
    checks++;
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b expected 0", bus.overflow); end
    checks++;
    if (bus.tx_din !== 8'h00) begin failures++; $display("FAIL rst_din: got %0h expected 00", bus.tx_din); end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    checks++;
    if (dbg_count !== '0) begin failures++; $display("FAIL rst_count: got %0d expected 0", dbg_count); end
`ifdef UART_TXQ_DROPCNT_EN
    checks++;
    if (drop_count !== 8'h00) begin failures++; $display("FAIL rst_drops: got %0d expected 0", drop_count); end
`endif
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    umode = 0;
    apply_reset();
    idle(3);
  endtask

  task automatic test_single_byte();
    int s0 = n_sent;
    umode = 0; fixed_dly = 2;
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (bus.tx_send !== 1'b0) begin failures++; $display("FAIL latency_early: got %b expected 0", bus.tx_send); end
    idle(1);
    checks++;
    if (bus.tx_send !== 1'b1) begin failures++; $display("FAIL latency: got %b expected 1", bus.tx_send); end
    checks++;
    if (bus.tx_din !== 8'h41) begin failures++; $display("FAIL single_din: got %0h expected 41", bus.tx_din); end
    drain();
    fixed_dly = 0;
    checks++;
    if (n_sent - s0 != 1) begin failures++; $display("FAIL single_count: got %0d expected 1", n_sent - s0); end
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_burst();
    int s0;
    umode = 1;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    idle(1);
    checks++;
    if (bus.full !== 1'b1) begin failures++; $display("FAIL burst_full: got %b expected 1", bus.full); end
    s0 = n_sent;
    umode = 0;
    drain();
    checks++;
    if (n_sent - s0 != 16) begin failures++; $display("FAIL burst_count: got %0d expected 16", n_sent - s0); end
  endtask

  task automatic test_overflow();
    int s0;
    umode = 1;
    for (int i = 0; i < 18; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(1);
    checks++;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
`ifdef UART_TXQ_DROPCNT_EN
    checks++;
    if (drop_count !== 8'd2) begin failures++; $display("FAIL ovf_drops: got %0d expected 2", drop_count); end
`endif
    s0 = n_sent;
    umode = 0;
    drain();
    checks++;
    if (n_sent - s0 != 16) begin failures++; $display("FAIL ovf_count: got %0d expected 16", n_sent - s0); end
    checks++;
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_clr_priority();
    umode = 1;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clr_priority: got %b expected 0", bus.overflow); end
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(1);
`ifdef UART_TXQ_DROPCNT_EN
    checks++;
    if (drop_count !== 8'hFF) begin failures++; $display("FAIL drop_sat: got %0d expected 255", drop_count); end
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    umode = 0;
    drain();
  endtask

  task automatic test_full_pop();
    umode = 1;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    umode = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    drain();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_wrap();
    int a0 = total_acc;
    int s0 = n_sent;
    int guard = 0;
    umode = 0;
    while (total_acc - a0 < 40 && guard < 3000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
      guard++;
    end
    drain();
    checks++;
    if (n_sent - s0 != 40) begin failures++; $display("FAIL wrap_count: got %0d expected 40", n_sent - s0); end
  endtask

  task automatic test_same_edge();
    int guard = 0;
    umode = 1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    umode = 0;
    pop_next = 0;
    while (!pop_next && guard < 100) begin
      cycle(1'b1, 8'hC3, 1'b0, 1'b1);
      guard++;
    end
    idle(1);
    checks++;
    if (dbg_count !== 5'd3) begin failures++; $display("FAIL same_edge_count: got %0d expected 3", dbg_count); end
    drain();
  endtask

  task automatic test_reset_mid_req();
    int s0;
    umode = 2;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(2);
    checks++;
    if (bus.tx_send !== 1'b1) begin failures++; $display("FAIL mid_req_send: got %b expected 1", bus.tx_send); end
    apply_reset();
    umode = 0;
    s0 = n_sent;
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    drain();
    checks++;
    if (n_sent - s0 != 1 || last_cap !== 8'hA5) begin
      failures++; $display("FAIL after_reset: got %0d bytes last %0h expected 1 byte a5", n_sent - s0, last_cap);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.clr_ovf = 1'b0; bus.tx_busy = 1'b0;
    n_sent = 0; total_acc = 0; fixed_dly = 0; last_cap = 8'h00;
    umode = 0;
    model_reset();
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_clr_priority();
    test_full_pop();
    test_wrap();
    test_same_edge();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_txq.md
UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 The block SHALL have parameter AWidth, default 4, meaning the log2 of FIFO depth (16 entries).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port wr_data, input, 8 bits, the byte to enqueue.
REQ-005 The block SHALL have port wr_en, input, 1 bit, an enqueue request sampled each clk.
REQ-006 The block SHALL have port full, output, 1 bit, high when count equals 2**AWidth.
REQ-007 The block SHALL have port empty, output, 1 bit, high when count equals 0.
REQ-008 The block SHALL have port overflow, output, 1 bit, a sticky flag set when a write is dropped.
REQ-009 The block SHALL have port clr_ovf, input, 1 bit, which clears overflow (and the drop counter, if built).
REQ-010 The block SHALL have port tx_din, output, 8 bits, the byte presented to the UART transmitter.
REQ-011 The block SHALL have port tx_send, output, 1 bit, the send request to the UART transmitter.
REQ-012 The block SHALL have port tx_busy, input, 1 bit, the UART transmitter busy indication.

Function
REQ-013 Storage SHALL be a circular buffer of 2**AWidth x 8 bits, with AWidth-bit read/write pointers that wrap modulo depth and an (AWidth+1)-bit count.
REQ-014 A write (wr_en=1 and full=0) SHALL store wr_data at the write pointer, advance the pointer and increment count on that edge.
REQ-015 A write attempted while full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs on the same edge.
REQ-016 A simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-017 full and empty SHALL be derived from the registered count with no combinational path from wr_en.
REQ-018 The sequencer SHALL use the states IDLE, REQ and WAIT.
REQ-019 IDLE: if empty=0 and tx_busy=0, the block SHALL load tx_din from the read pointer, set tx_send=1 and go to REQ; otherwise it SHALL stay in IDLE.
REQ-020 REQ: tx_send SHALL hold 1 and tx_din SHALL hold stable until tx_busy=1 is sampled.
REQ-021 On sampling tx_busy=1 in REQ, the block SHALL clear tx_send, pop the entry and go to WAIT.
REQ-022 WAIT: the block SHALL return to IDLE when tx_busy=0 is sampled.
REQ-023 Latency: a byte written on edge E into an empty FIFO with an idle UART SHALL appear with tx_send=1 after edge E+1.
REQ-024 tx_din SHALL change only on the IDLE->REQ transition.
REQ-025 A byte SHALL be popped exactly once, and only after tx_busy acknowledgement.
REQ-026 If tx_busy is already 1 in IDLE, the block SHALL wait in IDLE and SHALL NOT assert tx_send.
REQ-027 clr_ovf SHALL take priority over a same-edge overflow set.

Reset
REQ-028 While reset=1, regardless of clk, pointers and count SHALL be 0, empty=1, full=0, overflow=0, tx_send=0, tx_din=8'h00 and the state SHALL be IDLE.
REQ-029 Reset asserted mid-transfer SHALL discard all queued bytes and drop tx_send immediately.
REQ-030 Contents of the storage array need not be reset.

Configuration
REQ-031 With macro UART_TXQ_DROPCNT_EN defined, the block SHALL add output drop_count, 8 bits, which increments per dropped write, saturates at 255, and is cleared by reset or clr_ovf.
REQ-032 Without UART_TXQ_DROPCNT_EN, the drop_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Single byte: write 8'h41 with the UART model raising tx_busy 2 cycles after tx_send -> tx_send=1 one edge after the write, tx_din=8'h41, tx_send drops after tx_busy is seen, empty=1 after the pop.
REQ-034 Burst of 16 writes (8'h00..8'h0F) with tx_busy held 1 -> full=1, no tx_send; release tx_busy -> 16 bytes transmitted in order 00..0F.
REQ-035 Overflow: 18 writes with tx_busy held 1 -> overflow=1, drop_count=2 (when built), first 16 bytes delivered; clr_ovf -> overflow=0, drop_count=0.
REQ-036 Wrap-around: 40 bytes streamed with interleaved writes and pops -> output sequence equals input sequence, count never exceeds 16.
REQ-037 Reset mid-REQ with 5 bytes queued -> tx_send=0 immediately, empty=1; a subsequent write of 8'hA5 is the next byte sent.
REQ-038 Write and pop on the same edge while count=3 -> count stays 3 and data order is preserved.
